shape_column_gen: RTL

Sequential, parametrised successor to the combinational column generator for the rotating POV display. On each request it evaluates one or more display columns against a runtime-selected shape, radius and colour, one row per cycle through a 2-stage pipeline. It returns the finished columns under a valid/ready handshake to the panel scan driver. It sits between the rotation/column scheduler (requester) and the HUB75 column loader (consumer).

---
 rtl/shape_pkg.sv | 36 +++
 rtl/shape_point_test.sv | 95 +++++++++
 rtl/shape_column_gen.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shape_pkg.sv
// Shared types and width helpers for the POV shape column generator.
//   shape_mode_t : runtime shape select carried on mode_in
//   state_t      : request FSM states of shape_column_gen
//   coord_width  : width of a coordinate/distance (dx, dy) for a given panel
//   dist2_width  : width of dx^2 + dy^2 without truncation
package shape_pkg;

  typedef enum logic [1:0] {
    SHAPE_OFF     = 2'd0,
    SHAPE_SPHERE  = 2'd1,
    SHAPE_SHELL   = 2'd2,
    SHAPE_DIAMOND = 2'd3
  } shape_mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough for the column index, the row index and both centre offsets.
  function automatic int unsigned coord_width(input int unsigned cols,
                                              input int unsigned rows);
    int unsigned wc;
    int unsigned wr;
    wc = $clog2(cols);
    wr = $clog2(rows);
    return ((wc > wr) ? wc : wr) + 1;
  endfunction

  function automatic int unsigned dist2_width(input int unsigned cols,
                                              input int unsigned rows);
    return 2 * coord_width(cols, rows) + 1;
  endfunction

endpackage

// File: rtl/shape_point_test.sv
// Two-stage point test for one display channel.
//   Stage 1 (registered): dx = |col - CX|, dy = |row - CY|, out-of-range flag.
//   Stage 2 (combinational from stage 1): d^2 / r^2 comparison -> lit_out.
//   The caller registers lit_out, so a row issued on edge N is lit-resolved
//   for the write on edge N+1.
// Ports:
//   clk_in, rst_in   clock, synchronous active-low reset
//   col_idx_in       absolute column index (>= NUM_COLS means blank column)
//   row_in           row being issued this cycle
//   mode_in          shape select, held stable by the caller while in flight
//   radius_in        radius in pixels, held stable by the caller
//   lit_out          pixel result for the row captured on the previous edge
// Build option: SHAPE_COLUMN_GEN_SHELL_EN enables SHELL; otherwise SHELL = OFF.
module shape_point_test
  import shape_pkg::*;
#(
  parameter int unsigned NUM_COLS = 64,
  parameter int unsigned NUM_ROWS = 64
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [$clog2(NUM_COLS):0]  col_idx_in,
  input  logic [$clog2(NUM_ROWS):0]  row_in,
  input  shape_mode_t                mode_in,
  input  logic [$clog2(NUM_ROWS):0]  radius_in,
  output logic                       lit_out
);

  localparam int unsigned CW  = coord_width(NUM_COLS, NUM_ROWS);
  localparam int unsigned D2W = dist2_width(NUM_COLS, NUM_ROWS);
  localparam int unsigned CX  = NUM_COLS / 2;
  localparam int unsigned CY  = NUM_ROWS / 2;

  logic [CW-1:0] col_w;
  logic [CW-1:0] row_w;
  logic [CW-1:0] dx_d, dx_q;
  logic [CW-1:0] dy_d, dy_q;
  logic          oor_d, oor_q;

  // Stage 1: absolute offsets from the panel centre.
  always_comb begin
    col_w = CW'(col_idx_in);
    row_w = CW'(row_in);
    oor_d = (col_w >= CW'(NUM_COLS));
    dx_d  = (col_w >= CW'(CX)) ? (col_w - CW'(CX)) : (CW'(CX) - col_w);
    dy_d  = (row_w >= CW'(CY)) ? (row_w - CW'(CY)) : (CW'(CY) - row_w);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      dx_q  <= '0;
      dy_q  <= '0;
      oor_q <= 1'b0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      oor_q <= oor_d;
    end
  end

  // Stage 2: full-width squared distances, no truncation anywhere.
  logic [D2W-1:0] d2;
  logic [D2W-1:0] r2;
  logic [CW:0]    manhattan;
`ifdef SHAPE_COLUMN_GEN_SHELL_EN
  logic [CW-1:0]  rm1;
  logic [D2W-1:0] rm1_2;
`endif

  always_comb begin
    d2        = D2W'(dx_q) * D2W'(dx_q) + D2W'(dy_q) * D2W'(dy_q);
    r2        = D2W'(radius_in) * D2W'(radius_in);
    manhattan = (CW + 1)'(dx_q) + (CW + 1)'(dy_q);
`ifdef SHAPE_COLUMN_GEN_SHELL_EN
    rm1       = CW'(radius_in) - CW'(1);
    rm1_2     = D2W'(rm1) * D2W'(rm1);
`endif
    lit_out = 1'b0;
    if (!oor_q) begin
      case (mode_in)
        SHAPE_SPHERE:  lit_out = (d2 <= r2);
`ifdef SHAPE_COLUMN_GEN_SHELL_EN
        // r = 0 degenerates to the single centre pixel.
        SHAPE_SHELL:   lit_out = (radius_in == '0) ? (d2 == '0)
                                                   : ((d2 <= r2) && (d2 > rm1_2));
`else
        SHAPE_SHELL:   lit_out = 1'b0;
`endif
        SHAPE_DIAMOND: lit_out = (manhattan <= (CW + 1)'(radius_in));
        default:       lit_out = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/shape_column_gen.sv
// Sequential shape column generator for the rotating POV display.
// On an accepted request it latches the per-channel column indices, shape,
// radius and colour, then streams rows 0..NUM_ROWS-1 through one
// shape_point_test pipeline per channel and fills the result buffer. The
// finished columns are offered to the column loader under valid/ready.
// Ports:
//   clk_in, rst_in   clock, synchronous active-low reset
//   req_valid_in     request valid; req_ready_out high only in IDLE
//   col_index_in     per-channel column index, channel c at [c*IW +: IW]
//   mode_in          0 OFF, 1 SPHERE, 2 SHELL, 3 DIAMOND
//   radius_in        radius in pixels
//   color_in         colour of lit pixels
//   columns_out      pixel (c,row) at [(c*NUM_ROWS+row)*RGB_RES +: RGB_RES]
//   col_valid_out    result valid; col_ready_in consumer accept
//   busy_out         high while rows are being computed
// Build option: SHAPE_COLUMN_GEN_SHELL_EN enables SHELL mode (else mode 2 = OFF).
module shape_column_gen
  import shape_pkg::*;
#(
  parameter int unsigned SCAN_RATE    = 32,
  parameter int unsigned NUM_COLS     = 64,
  parameter int unsigned NUM_ROWS     = 64,
  parameter int unsigned RGB_RES      = 9,
  parameter int unsigned NUM_CHANNELS = 2
) (
  input  logic                                             clk_in,
  input  logic                                             rst_in,
  input  logic                                             req_valid_in,
  output logic                                             req_ready_out,
  input  logic [NUM_CHANNELS*($clog2(NUM_COLS)+1)-1:0]     col_index_in,
  input  logic [1:0]                                       mode_in,
  input  logic [$clog2(NUM_ROWS):0]                        radius_in,
  input  logic [RGB_RES-1:0]                               color_in,
  output logic [NUM_CHANNELS*NUM_ROWS*RGB_RES-1:0]         columns_out,
  output logic                                             col_valid_out,
  input  logic                                             col_ready_in,
  output logic                                             busy_out
);

  localparam int unsigned IW    = $clog2(NUM_COLS) + 1;
  localparam int unsigned RW    = $clog2(NUM_ROWS) + 1;
  localparam int unsigned BUF_W = NUM_CHANNELS * NUM_ROWS * RGB_RES;

  state_t                     state_d, state_q;
  logic [RW-1:0]              row_d, row_q;
  logic                       s1_valid_d, s1_valid_q;
  logic [RW-1:0]              s1_row_d, s1_row_q;
  logic                       wr_last_d, wr_last_q;
  logic [NUM_CHANNELS*IW-1:0] col_idx_d, col_idx_q;
  shape_mode_t                mode_d, mode_q;
  logic [RW-1:0]              radius_d, radius_q;
  logic [RGB_RES-1:0]         color_d, color_q;
  logic [BUF_W-1:0]           columns_d, columns_q;
  logic [NUM_CHANNELS-1:0]    lit;

  assign req_ready_out = (state_q == S_IDLE);
  assign busy_out      = (state_q == S_CALC);
  assign col_valid_out = (state_q == S_DONE);
  assign columns_out   = columns_q;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    shape_point_test #(
      .NUM_COLS (NUM_COLS),
      .NUM_ROWS (NUM_ROWS)
    ) u_point (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .col_idx_in (col_idx_q[c*IW +: IW]),
      .row_in     (row_q),
      .mode_in    (mode_q),
      .radius_in  (radius_q),
      .lit_out    (lit[c])
    );
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    s1_valid_d = 1'b0;
    s1_row_d   = row_q;
    // The last row is written on the edge after it leaves stage 1; DONE
    // follows one edge later so the buffer is complete when valid rises.
    wr_last_d  = s1_valid_q && (s1_row_q == RW'(NUM_ROWS - 1));
    col_idx_d  = col_idx_q;
    mode_d     = mode_q;
    radius_d   = radius_q;
    color_d    = color_q;
    columns_d  = columns_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid_in) begin
          state_d   = S_CALC;
          row_d     = '0;
          col_idx_d = col_index_in;
          mode_d    = shape_mode_t'(mode_in);
          radius_d  = radius_in;
          color_d   = color_in;
          columns_d = '0;
        end
      end
      S_CALC: begin
        if (row_q < RW'(NUM_ROWS)) begin
          row_d      = row_q + 1'b1;
          s1_valid_d = 1'b1;
        end
        if (wr_last_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (col_ready_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Row write for the row currently resolved by stage 2.
    if (s1_valid_q) begin
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        columns_d[(c * NUM_ROWS + int'(s1_row_q)) * RGB_RES +: RGB_RES] =
          lit[c] ? color_q : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_row_q   <= '0;
      wr_last_q  <= 1'b0;
      col_idx_q  <= '0;
      mode_q     <= SHAPE_OFF;
      radius_q   <= '0;
      color_q    <= '0;
      columns_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      s1_valid_q <= s1_valid_d;
      s1_row_q   <= s1_row_d;
      wr_last_q  <= wr_last_d;
      col_idx_q  <= col_idx_d;
      mode_q     <= mode_d;
      radius_q   <= radius_d;
      color_q    <= color_d;
      columns_q  <= columns_d;
    end
  end

endmodule
